// File: rtl/dcache_pkg.sv
// Shared FSM encodings and geometry helpers for the associative data cache.
package dcache_pkg;

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_MISS        = 3'd1;
  localparam logic [2:0] S_WRITEBACK   = 3'd2;
  localparam logic [2:0] S_REFILL      = 3'd3;
  localparam logic [2:0] S_REFILL_DONE = 3'd4;
  localparam logic [2:0] S_FLUSH_SCAN  = 3'd5;
  localparam logic [2:0] S_FLUSH_WB    = 3'd6;

  function automatic int off_w(input int line_bytes);
    return $clog2(line_bytes);
  endfunction

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int line_bytes, input int sets);
    return 32 - off_w(line_bytes) - idx_w(sets);
  endfunction

endpackage

// File: rtl/dcache_way_store.sv
// One cache way: valid/dirty/tag/data per set, async read, sync write at a shared index.
module dcache_way_store #(
  parameter int SETS  = 32,
  parameter int IDX   = 5,
  parameter int TAG_W = 22,
  parameter int LW    = 256
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [IDX-1:0]   idx,
  input  logic             we,
  input  logic             wvalid,
  input  logic             wdirty,
  input  logic [TAG_W-1:0] wtag,
  input  logic [LW-1:0]    wline,
  output logic             valid,
  output logic             dirty,
  output logic [TAG_W-1:0] tag,
  output logic [LW-1:0]    line
);

  logic [SETS-1:0]  valid_q, dirty_q;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [LW-1:0]    data_q [SETS];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (we) begin
      valid_q[idx] <= wvalid;
      dirty_q[idx] <= wdirty;
    end
  end

  // tag and line payload are meaningless until valid, so they carry no reset
  always_ff @(posedge clk_i) begin
    if (we) begin
      tag_q[idx]  <= wtag;
      data_q[idx] <= wline;
    end
  end

  assign valid = valid_q[idx];
  assign dirty = dirty_q[idx];
  assign tag   = tag_q[idx];
  assign line  = data_q[idx];

endmodule

// File: rtl/dcache_assoc.sv
// 1/2-way write-back data cache with LRU replacement and a full-cache flush walker.
module dcache_assoc
  import dcache_pkg::*;
#(
  parameter int LINE_BYTES = 32,
  parameter int SETS       = 32,
  parameter int WAYS       = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [31:0]             p1_addr_i,
  input  logic [31:0]             p1_data_i,
  input  logic [3:0]              p1_be_i,
  input  logic                    p1_MemRead_i,
  input  logic                    p1_MemWrite_i,
  output logic [31:0]             p1_data_o,
  output logic                    p1_stall_o,
  input  logic                    flush_i,
  output logic                    flush_busy_o,
  output logic [31:0]             mem_addr_o,
  output logic [LINE_BYTES*8-1:0] mem_data_o,
  output logic                    mem_enable_o,
  output logic                    mem_write_o,
  input  logic [LINE_BYTES*8-1:0] mem_data_i,
  input  logic                    mem_ack_i
);

  localparam int OFF   = off_w(LINE_BYTES);
  localparam int IDX   = idx_w(SETS);
  localparam int TAG_W = tag_w(LINE_BYTES, SETS);
  localparam int LW    = LINE_BYTES * 8;
  localparam int WORDS = LINE_BYTES / 4;
  localparam int CW    = IDX + 1;
  localparam logic [CW-1:0] LAST = CW'(WAYS * SETS - 1);

  logic [2:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            pend_q, enter_scan;
  logic            victim_q, victim_d, victim_c;
  logic            mem_en_q, mem_en_d, mem_wr_q, mem_wr_d;
  logic [SETS-1:0] lru_q;

  logic             req, hit, hit_way, flushing, scan_way, sel_way;
  logic [TAG_W-1:0] req_tag;
  logic [IDX-1:0]   req_idx, scan_set, idx;
  logic [OFF-3:0]   req_word;

  assign req      = p1_MemRead_i | p1_MemWrite_i;
  assign req_tag  = p1_addr_i[31 -: TAG_W];
  assign req_idx  = p1_addr_i[OFF +: IDX];
  assign req_word = p1_addr_i[OFF-1:2];
  assign flushing = (state_q == S_FLUSH_SCAN) || (state_q == S_FLUSH_WB);
  // scan counter is {set, way} so ways of a set are visited back to back
  assign scan_way = (WAYS == 2) ? cnt_q[0] : 1'b0;
  assign scan_set = (WAYS == 2) ? cnt_q[IDX:1] : cnt_q[IDX-1:0];
  assign idx      = flushing ? scan_set : req_idx;
  assign sel_way  = flushing ? scan_way : victim_q;

  logic [WAYS-1:0]            rd_valid, rd_dirty, way_hit, way_we;
  logic [WAYS-1:0][TAG_W-1:0] rd_tag;
  logic [WAYS-1:0][LW-1:0]    rd_line;
  logic                       wvalid, wdirty;
  logic [TAG_W-1:0]           wtag;
  logic [LW-1:0]              wline;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    dcache_way_store #(.SETS(SETS), .IDX(IDX), .TAG_W(TAG_W), .LW(LW)) u_store (
      .clk_i (clk_i),       .rst_i (rst_i),      .idx   (idx),
      .we    (way_we[w]),   .wvalid(wvalid),     .wdirty(wdirty),
      .wtag  (wtag),        .wline (wline),
      .valid (rd_valid[w]), .dirty (rd_dirty[w]),
      .tag   (rd_tag[w]),   .line  (rd_line[w])
    );
    assign way_hit[w] = rd_valid[w] && (rd_tag[w] == req_tag);
  end

  if (WAYS == 2) begin : g_two
    assign hit_way  = way_hit[1];
    assign victim_c = !rd_valid[0] ? 1'b0 : (!rd_valid[1] ? 1'b1 : lru_q[idx]);
  end else begin : g_one
    assign hit_way  = 1'b0;
    assign victim_c = 1'b0;
  end

  // requests are only served from IDLE; the retry after a refill lands there
  assign hit = (state_q == S_IDLE) && (|way_hit);

  logic [WORDS-1:0][3:0][7:0] hit_words, merged;
  assign hit_words = rd_line[hit_way];
  assign p1_data_o = hit_words[req_word];

  always_comb begin
    merged = hit_words;
    for (int b = 0; b < 4; b++)
      if (p1_be_i[b]) merged[req_word][b] = p1_data_i[8*b +: 8];
  end

  always_comb begin
    way_we = '0;
    wvalid = 1'b1;
    wdirty = 1'b0;
    wtag   = req_tag;
    wline  = mem_data_i;
    case (state_q)
      S_IDLE: if (hit && p1_MemWrite_i) begin
        way_we[hit_way] = 1'b1;
        wdirty          = 1'b1;
        wline           = merged;
      end
      S_REFILL: if (mem_ack_i) way_we[victim_q] = 1'b1;
      S_FLUSH_WB: if (mem_ack_i) begin
        way_we[scan_way] = 1'b1;
        wvalid           = rd_valid[scan_way];
        wtag             = rd_tag[scan_way];
        wline            = rd_line[scan_way];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    victim_d   = victim_q;
    mem_en_d   = mem_en_q;
    mem_wr_d   = mem_wr_q;
    enter_scan = 1'b0;
    case (state_q)
      S_IDLE:
        if (req && !hit) state_d = S_MISS;
        else if (pend_q) begin
          state_d    = S_FLUSH_SCAN;
          cnt_d      = '0;
          enter_scan = 1'b1;
        end
      S_MISS: begin
        victim_d = victim_c;
        mem_en_d = 1'b1;
        mem_wr_d = rd_valid[victim_c] && rd_dirty[victim_c];
        state_d  = mem_wr_d ? S_WRITEBACK : S_REFILL;
      end
      S_WRITEBACK: if (mem_ack_i) begin
        state_d  = S_REFILL;
        mem_wr_d = 1'b0;
      end
      S_REFILL: if (mem_ack_i) begin
        state_d  = S_REFILL_DONE;
        mem_en_d = 1'b0;
      end
      S_REFILL_DONE: state_d = S_IDLE;
      S_FLUSH_SCAN:
        if (rd_valid[scan_way] && rd_dirty[scan_way]) begin
          state_d  = S_FLUSH_WB;
          mem_en_d = 1'b1;
          mem_wr_d = 1'b1;
        end else if (cnt_q == LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 1'b1;
      S_FLUSH_WB: if (mem_ack_i) begin
        mem_en_d = 1'b0;
        mem_wr_d = 1'b0;
        state_d  = (cnt_q == LAST) ? S_IDLE : S_FLUSH_SCAN;
        cnt_d    = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      end
      default: begin
        state_d  = S_IDLE;
        mem_en_d = 1'b0;
        mem_wr_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      victim_q <= 1'b0;
      mem_en_q <= 1'b0;
      mem_wr_q <= 1'b0;
      pend_q   <= 1'b0;
      lru_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      victim_q <= victim_d;
      mem_en_q <= mem_en_d;
      mem_wr_q <= mem_wr_d;
      // a flush request arriving on the same edge as scan entry is kept for another pass
      if (flush_i) pend_q <= 1'b1;
      else if (enter_scan) pend_q <= 1'b0;
      if (hit) lru_q[req_idx] <= ~hit_way;
    end
  end

  always_comb begin
    case (state_q)
      S_WRITEBACK, S_FLUSH_WB: mem_addr_o = {rd_tag[sel_way], idx, {OFF{1'b0}}};
      S_REFILL:                mem_addr_o = {req_tag, req_idx, {OFF{1'b0}}};
      default:                 mem_addr_o = '0;
    endcase
  end

  assign mem_data_o   = rd_line[sel_way];
  assign mem_enable_o = mem_en_q;
  assign mem_write_o  = mem_wr_q;
  assign flush_busy_o = pend_q | flushing;
  assign p1_stall_o   = (req && !hit) || flushing;

  logic unused_addr;
  assign unused_addr = ^p1_addr_i[1:0];

endmodule

// File: tb/tb_dcache_assoc.sv
// Directed bench: flat-memory architectural model checked on every served request.
module tb_dcache_assoc;
  localparam int LAT = 3;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [31:0]  p1_addr_i, p1_data_i, p1_data_o;
  logic [3:0]   p1_be_i;
  logic         p1_MemRead_i, p1_MemWrite_i, p1_stall_o;
  logic         flush_i, flush_busy_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o, mem_data_i;
  logic         mem_enable_o, mem_write_o, mem_ack_i;

  always #5 clk_i = ~clk_i;

  dcache_assoc #(.LINE_BYTES(32), .SETS(32), .WAYS(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .p1_addr_i(p1_addr_i), .p1_data_i(p1_data_i), .p1_be_i(p1_be_i),
    .p1_MemRead_i(p1_MemRead_i), .p1_MemWrite_i(p1_MemWrite_i),
    .p1_data_o(p1_data_o), .p1_stall_o(p1_stall_o),
    .flush_i(flush_i), .flush_busy_o(flush_busy_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
    .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] mem_bk [int];  // backing memory, word addressed
  logic [31:0] model  [int];  // what a processor read must return
  typedef struct { bit wr; logic [31:0] addr; } txn_t;
  txn_t log_q[$];

  function automatic logic [31:0] init_word(input int wa);
    return {8'hD0, 24'(wa << 2)};
  endfunction

  function automatic logic [31:0] bk_rd(input int wa);
    return mem_bk.exists(wa) ? mem_bk[wa] : init_word(wa);
  endfunction

  function automatic logic [31:0] model_rd(input int wa);
    return model.exists(wa) ? model[wa] : init_word(wa);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic expect_txn(input string name, input int i, input bit wr, input logic [31:0] a);
    if (i >= log_q.size()) begin
      total++;
      bad++;
      $display("FAIL %s: got %0d transactions want more than %0d", name, log_q.size(), i);
    end else begin
      check({name, "_kind"}, 32'(log_q[i].wr), 32'(wr));
      check({name, "_addr"}, log_q[i].addr, a);
    end
  endtask

  // memory: ack LAT cycles after enable is seen, one-cycle pulse
  initial begin
    int cnt;
    int wa;
    cnt = 0;
    mem_ack_i = 1'b0;
    mem_data_i = '0;
    forever begin
      @(negedge clk_i);
      mem_ack_i = 1'b0;
      if (rst_i !== 1'b1 || !mem_enable_o) cnt = 0;
      else begin
        cnt++;
        if (cnt == LAT) begin
          cnt = 0;
          mem_ack_i = 1'b1;
          log_q.push_back('{mem_write_o, mem_addr_o});
          for (int w = 0; w < 8; w++) begin
            wa = int'(mem_addr_o >> 2) + w;
            if (mem_write_o) mem_bk[wa] = mem_data_o[w*32 +: 32];
            else mem_data_i[w*32 +: 32] = bk_rd(wa);
          end
        end
      end
    end
  end

  // every served request is checked against the architectural model
  initial begin
    int wa;
    logic [31:0] w;
    forever begin
      @(negedge clk_i);
      if (rst_i === 1'b1 && (p1_MemRead_i || p1_MemWrite_i) && !p1_stall_o) begin
        wa = int'(p1_addr_i >> 2);
        w  = model_rd(wa);
        if (p1_MemRead_i) check("served_rdata", p1_data_o, w);
        if (p1_MemWrite_i) begin
          for (int b = 0; b < 4; b++)
            if (p1_be_i[b]) w[8*b +: 8] = p1_data_i[8*b +: 8];
          model[wa] = w;
        end
      end
      if (rst_i === 1'b1 && mem_write_o) check("wr_implies_en", 32'(mem_enable_o), 32'd1);
    end
  end

  task automatic access(input logic [31:0] a, input bit rd, input bit wr, input logic [31:0] d,
                        input logic [3:0] be, output int stalls, output logic [31:0] data);
    p1_addr_i = a; p1_MemRead_i = rd; p1_MemWrite_i = wr; p1_data_i = d; p1_be_i = be;
    stalls = 0;
    data = 'x;
    forever begin
      @(negedge clk_i);
      if (!p1_stall_o) begin
        data = p1_data_o;
        break;
      end
      stalls++;
      if (stalls > 300) begin
        total++;
        bad++;
        $display("FAIL access_timeout: got %0d stall cycles want under 300", stalls);
        break;
      end
    end
    @(posedge clk_i); #1;
    p1_MemRead_i = 1'b0; p1_MemWrite_i = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    model = mem_bk;
    log_q.delete();
  endtask

  task automatic run_flush(input string name);
    int cyc;
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    @(negedge clk_i);
    check({name, "_busy_on"}, 32'(flush_busy_o), 32'd1);
    @(negedge clk_i);
    check({name, "_stall"}, 32'(p1_stall_o), 32'd1);
    cyc = 0;
    while (flush_busy_o && cyc < 1000) begin
      @(negedge clk_i);
      cyc++;
    end
    check({name, "_busy_off"}, 32'(flush_busy_o), 32'd0);
    @(posedge clk_i); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200us");
    $fatal(1);
  end

  initial begin
    int st, cyc;
    logic [31:0] rd;
    rst_i = 1'b0; flush_i = 1'b0;
    p1_addr_i = '0; p1_data_i = '0; p1_be_i = '0; p1_MemRead_i = 1'b0; p1_MemWrite_i = 1'b0;
    mem_bk[32'h044 >> 2] = 32'hAAAAAAAA;
    model = mem_bk;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_en", 32'(mem_enable_o), 32'd0);
    check("rst_wr", 32'(mem_write_o), 32'd0);
    check("rst_busy", 32'(flush_busy_o), 32'd0);
    check("rst_stall", 32'(p1_stall_o), 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(posedge clk_i); #1;

    // cold read, then the neighbouring word of the refilled line
    access(32'h040, 1, 0, 0, 4'h0, st, rd);
    check("cold_stalls", st, 32'd6);
    check("cold_data", rd, 32'hD0000040);
    check("cold_txns", log_q.size(), 32'd1);
    expect_txn("cold_refill", 0, 0, 32'h040);
    access(32'h044, 1, 0, 0, 4'h0, st, rd);
    check("word1_stalls", st, 32'd0);
    check("word1_data", rd, 32'hAAAAAAAA);

    // partial write hit, and read+write returning the old word
    access(32'h044, 0, 1, 32'h12345678, 4'b0011, st, rd);
    check("wrhit_stalls", st, 32'd0);
    access(32'h044, 1, 0, 0, 4'h0, st, rd);
    check("merge_stalls", st, 32'd0);
    check("merge_data", rd, 32'hAAAA5678);
    access(32'h048, 1, 1, 32'h55667788, 4'hF, st, rd);
    check("rw_old_word", rd, 32'hD0000048);
    access(32'h048, 1, 0, 0, 4'h0, st, rd);
    check("rw_new_word", rd, 32'h55667788);

    // LRU: 0x440 is least recent when 0x840 arrives
    do_reset();
    access(32'h040, 1, 0, 0, 4'h0, st, rd);
    access(32'h440, 1, 0, 0, 4'h0, st, rd);
    check("lru_fill2_stalls", st, 32'd6);
    access(32'h040, 1, 0, 0, 4'h0, st, rd);
    check("lru_touch_stalls", st, 32'd0);
    access(32'h840, 1, 0, 0, 4'h0, st, rd);
    check("lru_evict_stalls", st, 32'd6);
    check("lru_txns", log_q.size(), 32'd3);
    expect_txn("lru_refill", 2, 0, 32'h840);
    access(32'h040, 1, 0, 0, 4'h0, st, rd);
    check("lru_keep_stalls", st, 32'd0);
    access(32'h440, 1, 0, 0, 4'h0, st, rd);
    check("lru_gone_stalls", st, 32'd6);

    // dirty victim: writeback precedes refill
    do_reset();
    access(32'h040, 0, 1, 32'hCAFEF00D, 4'hF, st, rd);
    check("wrmiss_stalls", st, 32'd6);
    access(32'h440, 1, 0, 0, 4'h0, st, rd);
    access(32'h440, 1, 0, 0, 4'h0, st, rd);
    log_q.delete();
    access(32'h840, 1, 0, 0, 4'h0, st, rd);
    check("wb_stalls", st, 32'd9);
    check("wb_txns", log_q.size(), 32'd2);
    expect_txn("wb_write", 0, 1, 32'h040);
    expect_txn("wb_refill", 1, 0, 32'h840);
    check("wb_mem_data", bk_rd(32'h040 >> 2), 32'hCAFEF00D);
    access(32'h040, 1, 0, 0, 4'h0, st, rd);
    check("wb_reread", rd, 32'hCAFEF00D);

    // flush: dirty lines at sets 7 and 2 written back in set order
    do_reset();
    access(32'h0E0, 0, 1, 32'h0E0E0E0E, 4'hF, st, rd);
    access(32'h040, 0, 1, 32'h04040404, 4'hF, st, rd);
    log_q.delete();
    run_flush("flush1");
    check("flush1_txns", log_q.size(), 32'd2);
    expect_txn("flush1_first", 0, 1, 32'h040);
    expect_txn("flush1_second", 1, 1, 32'h0E0);
    check("flush1_mem040", bk_rd(32'h040 >> 2), 32'h04040404);
    check("flush1_mem0e0", bk_rd(32'h0E0 >> 2), 32'h0E0E0E0E);
    access(32'h040, 1, 0, 0, 4'h0, st, rd);
    check("flush1_hit040", st, 32'd0);
    access(32'h0E0, 1, 0, 0, 4'h0, st, rd);
    check("flush1_hit0e0", st, 32'd0);
    log_q.delete();
    run_flush("flush2");
    check("flush2_clean_txns", log_q.size(), 32'd0);

    // reset in the middle of a refill
    do_reset();
    p1_addr_i = 32'h100; p1_MemRead_i = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk_i);
      cyc++;
    end while (!mem_enable_o && cyc < 50);
    check("midrst_en_seen", 32'(mem_enable_o), 32'd1);
    #2;
    rst_i = 1'b0;
    #1;
    check("midrst_en", 32'(mem_enable_o), 32'd0);
    check("midrst_wr", 32'(mem_write_o), 32'd0);
    check("midrst_busy", 32'(flush_busy_o), 32'd0);
    p1_MemRead_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    model = mem_bk;
    access(32'h100, 1, 0, 0, 4'h0, st, rd);
    check("midrst_remiss", st, 32'd6);
    check("midrst_data", rd, 32'hD0000100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
